// File: rtl/demultiplexer_32_staged.sv
// Registered 1:32 bit demultiplexer with staging and an atomic publish to DemuxOut.
// Zero cycles from a commit edge to DemuxOut; no backpressure, so a write is accepted on any edge with Enable high.
module demultiplexer_32_staged #(
    parameter bit AUTO_COMMIT = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        DemuxIn,
    input  logic [4:0]  Sel,
    input  logic        Write,
    input  logic        AutoInc,
    input  logic        Commit,
    input  logic        Clear,
    output logic [31:0] DemuxOut,
    output logic [4:0]  Ptr,
    output logic        Wrap
);

    logic [31:0] stage;
    logic [31:0] stageNext;
    logic [4:0]  idx;
    logic        writeAcc;
    logic        wrapEvt;
    logic        commitEvt;

    always_comb begin
        idx       = AutoInc ? Ptr : Sel;
        writeAcc  = Enable & Write & ~Clear;
        wrapEvt   = writeAcc & AutoInc & (Ptr == 5'd31);
        commitEvt = (Enable & Commit & ~Clear) | (AUTO_COMMIT & wrapEvt);
        stageNext = stage;
        if (writeAcc) begin
            stageNext[idx] = DemuxIn;
        end
    end

    // The published word includes this cycle's write so write+commit on one edge shows the new bit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stage    <= 32'd0;
            DemuxOut <= 32'd0;
            Ptr      <= 5'd0;
            Wrap     <= 1'b0;
        end else if (Clear) begin
            stage    <= 32'd0;
            DemuxOut <= 32'd0;
            Ptr      <= 5'd0;
            Wrap     <= 1'b0;
        end else begin
            stage <= stageNext;
            Wrap  <= wrapEvt;
            if (commitEvt) begin
                DemuxOut <= stageNext;
            end
            if (writeAcc && AutoInc) begin
                Ptr <= Ptr + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_demultiplexer_32_staged.sv
// Directed bench driving one AUTO_COMMIT=1 and one AUTO_COMMIT=0 instance from shared inputs.
module tb_demultiplexer_32_staged;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic        DemuxIn;
    logic [4:0]  Sel;
    logic        Write;
    logic        AutoInc;
    logic        Commit;
    logic        Clear;
    logic [31:0] demuxOut1, demuxOut0;
    logic [4:0]  ptr1, ptr0;
    logic        wrap1, wrap0;

    int vectors;
    int miscompares;
    logic [31:0] pattern;

    demultiplexer_32_staged #(.AUTO_COMMIT(1'b1)) dutAuto (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .DemuxIn(DemuxIn),
        .Sel(Sel), .Write(Write), .AutoInc(AutoInc), .Commit(Commit),
        .Clear(Clear), .DemuxOut(demuxOut1), .Ptr(ptr1), .Wrap(wrap1)
    );

    demultiplexer_32_staged #(.AUTO_COMMIT(1'b0)) dutManual (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .DemuxIn(DemuxIn),
        .Sel(Sel), .Write(Write), .AutoInc(AutoInc), .Commit(Commit),
        .Clear(Clear), .DemuxOut(demuxOut0), .Ptr(ptr0), .Wrap(wrap0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        Reset = 0; Enable = 0; DemuxIn = 0; Sel = 0; Write = 0;
        AutoInc = 0; Commit = 0; Clear = 0;

        // Asynchronous reset mid-cycle, checked before any clock edge sees it
        #13 Reset = 1;
        #1;
        chk("rst_out1", demuxOut1, 32'h0);
        chk("rst_out0", demuxOut0, 32'h0);
        chk("rst_ptr1", {27'd0, ptr1}, 32'd0);
        chk("rst_wrap1", {31'd0, wrap1}, 32'd0);
        #3 Reset = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_out1", demuxOut1, 32'h0);
            chk("idle_ptr1", {27'd0, ptr1}, 32'd0);
            chk("idle_wrap1", {31'd0, wrap1}, 32'd0);
        end

        // Addressed writes to 0, 5, 31, then commit
        Enable = 1; AutoInc = 0; Write = 1; DemuxIn = 1;
        Sel = 5'd0;  step(); chk("addr0_out", demuxOut1, 32'h0);  chk("addr0_ptr", {27'd0, ptr1}, 32'd0);
        Sel = 5'd5;  step(); chk("addr5_out", demuxOut1, 32'h0);  chk("addr5_ptr", {27'd0, ptr1}, 32'd0);
        Sel = 5'd31; step(); chk("addr31_out", demuxOut1, 32'h0); chk("addr31_ptr", {27'd0, ptr1}, 32'd0);
        Write = 0; Commit = 1;
        step();
        chk("addr_commit1", demuxOut1, 32'h8000_0021);
        chk("addr_commit0", demuxOut0, 32'h8000_0021);
        chk("addr_commit_ptr", {27'd0, ptr1}, 32'd0);
        Commit = 0;

        // Serial auto fill, LSB first
        pattern = 32'hA5C3_0F1E;
        AutoInc = 1; Write = 1;
        for (int i = 0; i < 32; i++) begin
            DemuxIn = pattern[i];
            step();
            if (i < 31) begin
                chk("fill_wrap1", {31'd0, wrap1}, 32'd0);
                chk("fill_ptr1", {27'd0, ptr1}, i + 1);
            end
            if (i == 15) chk("fill_mid_out1", demuxOut1, 32'h8000_0021);
        end
        chk("fill_out1", demuxOut1, 32'hA5C3_0F1E);
        chk("fill_wrap1_hi", {31'd0, wrap1}, 32'd1);
        chk("fill_ptr1_end", {27'd0, ptr1}, 32'd0);
        chk("fill_out0_held", demuxOut0, 32'h8000_0021);
        chk("fill_wrap0_hi", {31'd0, wrap0}, 32'd1);
        Write = 0;
        step();
        chk("fill_wrap1_lo", {31'd0, wrap1}, 32'd0);
        chk("fill_out1_hold", demuxOut1, 32'hA5C3_0F1E);

        // Write and commit on the same edge publish the new bit
        AutoInc = 0; Sel = 5'd7; DemuxIn = 1; Write = 1; Commit = 1;
        step();
        chk("wc_out1", demuxOut1, 32'hA5C3_0F9E);
        chk("wc_out0", demuxOut0, 32'hA5C3_0F9E);

        // Clear dominates a simultaneous write and commit
        Clear = 1; Sel = 5'd3;
        step();
        chk("clr_out1", demuxOut1, 32'h0);
        chk("clr_out0", demuxOut0, 32'h0);
        chk("clr_ptr1", {27'd0, ptr1}, 32'd0);
        chk("clr_wrap1", {31'd0, wrap1}, 32'd0);
        Clear = 0; Write = 0; Commit = 1;
        step();
        chk("clr_dropped1", demuxOut1, 32'h0);
        chk("clr_dropped0", demuxOut0, 32'h0);
        Commit = 0;

        // Build a nonzero state for the enable test
        AutoInc = 1; Write = 1; DemuxIn = 1;
        repeat (3) step();
        Write = 0; Commit = 1;
        step();
        chk("en_pre_out1", demuxOut1, 32'h7);
        chk("en_pre_ptr1", {27'd0, ptr1}, 32'd3);
        Commit = 0;

        Enable = 0; DemuxIn = 0;
        for (int i = 0; i < 10; i++) begin
            Write = 1; Commit = 1;
            step();
            chk("en_out1", demuxOut1, 32'h7);
            chk("en_out0", demuxOut0, 32'h7);
            chk("en_ptr1", {27'd0, ptr1}, 32'd3);
        end
        Write = 0; Commit = 0; Clear = 1;
        step();
        chk("en_clr_out1", demuxOut1, 32'h0);
        chk("en_clr_ptr1", {27'd0, ptr1}, 32'd0);
        chk("en_clr_ptr0", {27'd0, ptr0}, 32'd0);
        Clear = 0;

        // 32 auto writes of ones: only the auto-commit instance publishes on wrap
        Enable = 1; AutoInc = 1; Write = 1; DemuxIn = 1;
        repeat (32) step();
        chk("m_wrap0", {31'd0, wrap0}, 32'd1);
        chk("m_out0", demuxOut0, 32'h0);
        chk("m_ptr0", {27'd0, ptr0}, 32'd0);
        chk("m_out1", demuxOut1, 32'hFFFF_FFFF);
        Write = 0; Commit = 1;
        step();
        chk("m_commit_out0", demuxOut0, 32'hFFFF_FFFF);
        chk("m_commit_wrap0", {31'd0, wrap0}, 32'd0);
        Commit = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demultiplexer_32_staged.md
# demultiplexer_32_staged

Registered 1-to-32 demultiplexer with a double-buffered output word: the write-side counterpart of the 32:1 bit-select multiplexers in the datapath. It scatters a serial bit stream, or individually addressed bits, into a 32-bit staging register and publishes the staged word atomically to `DemuxOut`. The Tetris display path uses it to assemble a playfield row bit-by-bit and update the row latch without tearing.

## Interface
- `AUTO_COMMIT`, default 1: 1 = a write that wraps the pointer also commits staging to `DemuxOut`; 0 = only `Commit` publishes.
- `Clock`  in  1  single system clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Enable`  in  1  gates `Write` and `Commit`; low = both ignored, all state holds.
- `DemuxIn`  in  1  data bit to deposit.
- `Sel`  in  5  destination bit index when `AutoInc`=0.
- `Write`  in  1  write strobe; accepted when `Enable`=1.
- `AutoInc`  in  1  1 = destination is the internal pointer `Ptr`, and `Ptr` advances on each accepted write.
- `Commit`  in  1  copy staging to `DemuxOut`; accepted when `Enable`=1.
- `Clear`  in  1  synchronous clear of staging, `DemuxOut` and `Ptr`; not gated by `Enable`.
- `DemuxOut`  out  32  published word; bit i is the value written to index i.
- `Ptr`  out  5  current auto-increment pointer.
- `Wrap`  out  1  one-cycle pulse after the pointer wraps from 31 to 0.

## Operation
- State:
  - `stage[31:0]`, `DemuxOut[31:0]`, `Ptr[4:0]`, `Wrap`.
  - There is no other FSM. Behaviour is a two-state cycle, Filling/Published, implied by the commits.
- Destination index: `idx = AutoInc ? Ptr : Sel`.
- Accepted write (`Enable & Write & ~Clear`):
  - `stage[idx] <= DemuxIn`. All other staging bits hold.
- Pointer:
  - On an accepted write with `AutoInc`=1, `Ptr <= Ptr+1` modulo 32; 31 wraps to 0.
  - A write with `AutoInc`=0 leaves `Ptr` unchanged.
- Wrap event: accepted write with `AutoInc`=1 and `Ptr`=31.
- Commit event: `Enable & Commit & ~Clear`, or (`AUTO_COMMIT`=1 and a wrap event).
  - On a commit event, `DemuxOut` takes the staging word with that cycle's write merged in. Write and commit on the same edge publish the new bit.
- Clear (highest synchronous priority):
  - `stage`, `DemuxOut` and `Ptr` go to 0 and `Wrap` to 0.
  - Any same-cycle write or commit is dropped.
- `Enable`=0 with `Clear`=0: nothing changes. `Wrap` still deasserts.
- Staging is not cleared by a commit. Unwritten bits retain their previous values into the next word.

## Timing
- Reset (asynchronous, immediate): `DemuxOut`=0, `stage`=0, `Ptr`=0, `Wrap`=0. Release is synchronous to the first following `Clock` edge.
- Write to `DemuxOut` latency:
  - 0 cycles beyond the commit edge. A bit written at edge k with a commit at edge k is visible on `DemuxOut` after edge k.
  - A bit written at edge k with no commit is not visible until the next commit edge.
- `Ptr` updates at the same edge as the accepted write.
- `Wrap`:
  - Registered. High for exactly the one cycle following the wrap-event edge.
  - With `AUTO_COMMIT`=1 it coincides with the first cycle in which the new word is on `DemuxOut`.
- Back-to-back writes every cycle are supported. 32 consecutive auto writes produce exactly one `Wrap` pulse and, with `AUTO_COMMIT`=1, one publish.
- Mode mixing: switching `AutoInc` between writes is legal. `Ptr` only advances on auto writes.
- Reset mid-fill: the partially staged word is lost and `Ptr` returns to 0.
- No combinational path from any input to any output. All outputs are registers.

## Test plan
- Reset then idle:
  - Assert `Reset` asynchronously mid-cycle.
  - Require `DemuxOut`=0x00000000, `Ptr`=0, `Wrap`=0 immediately, and held for 5 idle cycles.
- Addressed writes:
  - Stimulus: `AutoInc`=0; write 1 to `Sel`=0, 5, 31, then pulse `Commit`.
  - Require `DemuxOut` unchanged (0) until the commit edge, then 0x80000021.
  - Require `Ptr`=0 throughout.
- Auto fill with `AUTO_COMMIT`=1:
  - Stimulus: stream 32 bits of 0xA5C3_0F1E, LSB first, one per cycle.
  - Require `DemuxOut`=0xA5C30F1E after the 32nd write edge and `Wrap`=1 for exactly that following cycle.
  - Require `Ptr`=0 afterwards.
- Simultaneous events:
  - Write 1 to `Sel`=7 with `Commit` on the same edge: require bit 7 set on `DemuxOut` next cycle.
  - `Clear`+`Write`+`Commit` together: require all outputs 0 and the write dropped.
- Enable gating:
  - Stimulus: `Enable`=0 with `Write`/`Commit` pulsed for 10 cycles.
  - Require no change to `DemuxOut`/`Ptr`.
  - Then `Clear` with `Enable`=0: require outputs cleared.
- `AUTO_COMMIT`=0 wrap:
  - Stimulus: 32 auto writes of all-ones.
  - Require `Wrap` pulse, `DemuxOut` still 0, `Ptr`=0.
  - After `Commit`, require 0xFFFFFFFF.
